// File: rtl/sum_pkg.sv
// Shared definitions for the byte-serial adder/subtractor: state encoding,
// adder slice width and a constant-evaluable ceiling-log2 helper.
package sum_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of bits needed to index n items (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sum_sequencer_byte_adder.sv
// Combinational 8-bit slice adder with carry in/out; the single arithmetic
// resource that the sequencer time-multiplexes across operand bytes.
module byte_adder
  import sum_pkg::*;
(
  input  logic [BYTE_W-1:0] x,
  input  logic [BYTE_W-1:0] y,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);

  logic [BYTE_W:0] sum;

  assign sum       = {1'b0, x} + {1'b0, y} + {{BYTE_W{1'b0}}, cin};
  assign {cout, s} = sum;

endmodule

// File: rtl/sum_sequencer.sv
// Multi-precision add/subtract: one byte per cycle, LSB first, carry held in a
// flop between bytes. The result register only updates on the done cycle.
module sum_sequencer
  import sum_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      sub,
  input  logic [WORD_BYTES*8-1:0]   a,
  input  logic [WORD_BYTES*8-1:0]   b,
  output logic                      busy,
  output logic                      done,
  output logic [WORD_BYTES*8:0]     result
);

  localparam int                IDX_W    = clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_BYTES - 1);

  state_t                          state;
  state_t                          state_nxt;
  logic [IDX_W-1:0]                idx;
  logic                            carry;
  logic                            sub_q;
  logic [WORD_BYTES-1:0][BYTE_W-1:0] a_q;
  logic [WORD_BYTES-1:0][BYTE_W-1:0] b_q;
  logic [WORD_BYTES-1:0][BYTE_W-1:0] stage_q;
  logic                            stage_msb;
  logic [BYTE_W-1:0]               x_byte;
  logic [BYTE_W-1:0]               y_byte;
  logic [BYTE_W-1:0]               s_byte;
  logic                            cout;
  logic                            last_byte;

  // Subtraction inverts B here; the +1 comes from carry being preset to sub.
  assign x_byte    = a_q[idx];
  assign y_byte    = b_q[idx] ^ {BYTE_W{sub_q}};
  assign last_byte = (idx == LAST_IDX);
  assign busy      = (state != IDLE);

  byte_adder u_adder (
    .x    (x_byte),
    .y    (y_byte),
    .cin  (carry),
    .s    (s_byte),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_byte) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, byte stepping and staging of partial results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      stage_q   <= '0;
      stage_msb <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            carry <= sub;
            idx   <= '0;
          end
        end
        RUN: begin
          stage_q[idx] <= s_byte;
          carry        <= cout;
          if (last_byte) begin
            stage_msb <= cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result publishes whole-word only, so partial bytes are never visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        result <= {stage_msb, stage_q};
      end
    end
  end

endmodule

// File: tb/tb_sum_sequencer.sv
// Self-checking bench for sum_sequencer (WORD_BYTES=4): directed vectors,
// mid-run reset, and a continuous-start random stream against a word model.
module tb_sum_sequencer;

  localparam int WB = 4;
  localparam int W  = WB * 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W:0]   result;

  int n_cmp = 0;
  int n_err = 0;

  sum_sequencer #(.WORD_BYTES(WB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-word arithmetic: sum is exact; difference flags "no borrow" in the MSB.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s);
    logic [W-1:0] diff;
    if (s) begin
      diff = x - y;
      return {(x >= y) ? 1'b1 : 1'b0, diff};
    end
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic [W:0] exp);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~x; b = $urandom; sub = ~s;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(WB + 1));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(WB + 1));
    check({tag, " result"}, 64'(result), 64'(exp));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    check({tag, " result_held"}, 64'(result), 64'(exp));
  endtask

  initial begin
    logic [W:0] q[$];
    logic [W:0] held;
    int cyc;
    int last_done;
    int ndone;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_small",   32'h000000F0, 32'h0000000F, 1'b0, 33'h0_000000FF);
    run_op("add_max",     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33'h1_FFFFFFFE);
    run_op("add_ripple",  32'h00FFFFFF, 32'h00000001, 1'b0, 33'h0_01000000);
    run_op("sub_pos",     32'd5,        32'd3,        1'b1, 33'h1_00000002);
    run_op("sub_neg",     32'd3,        32'd5,        1'b1, 33'h0_FFFFFFFE);
    run_op("sub_equal",   32'h12345678, 32'h12345678, 1'b1, 33'h1_00000000);

    // Reset while byte index 2 is being processed.
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h01010101; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrun busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrun busy", 64'(busy), 64'd0);
    check("midrun done", 64'(done), 64'd0);
    check("midrun result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < WB + 3; i++) begin
      @(posedge clk);
      #1;
      check("midrun no_done", 64'(done), 64'd0);
    end
    run_op("after_reset", 32'hDEADBEEF, 32'h01010101, 1'b0, 33'h0_DFAEBFF0);

    // Continuous start with operands changing every cycle.
    held = result; cyc = 0; last_done = -1; ndone = 0;
    while (ndone < 200 && cyc < 3000) begin
      @(negedge clk);
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) b = a;
      start = 1'b1;
      if (!busy) q.push_back(model(a, b, sub));
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        if (q.size() == 0) check("stream unexpected_done", 64'd1, 64'd0);
        else check("stream result", 64'(result), 64'(q.pop_front()));
        if (last_done >= 0) check("stream spacing", 64'(cyc - last_done), 64'(WB + 2));
        last_done = cyc;
        held = result;
        ndone++;
      end else begin
        check("stream hold", 64'(result), 64'(held));
      end
    end
    start = 1'b0;
    check("stream done_count", 64'(ndone), 64'd200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
